sprite_line_fetcher: RTL
========================

Name: sprite_line_fetcher

Overview:
- Reader side of the sprite ROM line interface.
- Before each display line, walks an entity table and finds entities whose 8-row sprite covers the current line. For each hit, drives the ROM read signals (sprite ID, orientation, line index) and captures the returned 8-bit active-low row into a slot buffer.
- During active video, turns slot contents plus hpos into a per-pixel on/entity stream for the pixel mixer.

Parameters:
- NUM_ENT, 8, entities in the table (power of 2, >=2).
- NUM_SLOTS, 4, maximum sprites captured per line.
- HW, 10, width of horizontal coordinates.
- VW, 10, width of vertical coordinates.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- line_start  in  1  single-cycle pulse; begin fetch for line_y.
- line_y  in  VW  line to fetch; sampled with line_start.
- ent_idx  out  log2(NUM_ENT)  entity table index (combinational from internal counter).
- ent_valid  in  1  entity present; valid in the same cycle as ent_idx.
- ent_id  in  4  sprite ID.
- ent_orient  in  2  orientation: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
- ent_x  in  HW  left column.
- ent_y  in  VW  top row.
- rom_read_enable  out  1  ROM read strobe (registered).
- rom_sprite_ID  out  4  registered.
- rom_orientation  out  2  registered.
- rom_line_index  out  3  registered.
- rom_data  in  8  ROM row; combinational from the registered address; 0 = pixel on.
- line_ready  out  1  slot buffer valid for the current line.
- overflow  out  1  more than NUM_SLOTS hits on this line; sticky until next line_start.
- hpos  in  HW  current pixel column.
- pixel_on  out  1  opaque sprite pixel at hpos (registered).
- pixel_ent  out  log2(NUM_ENT)  entity index owning pixel_on.

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0, all slots marked empty.
- FSM states: IDLE, SCAN, FETCH, DONE.
- IDLE / DONE + line_start:
  - latch line_y; idx=0; count=0.
  - clear overflow, line_ready and all slot valid bits.
  - go to SCAN.
- SCAN, one entity per cycle:
  - d = {1'b0,line_y} - {1'b0,ent_y}, computed VW+1 wide.
  - hit = ent_valid && d < 8. line_y < ent_y gives a large d, so no hit.
  - hit and count < NUM_SLOTS: register rom_read_enable=1, rom_sprite_ID=ent_id, rom_orientation=ent_orient, rom_line_index=d[2:0]; latch ent_x and idx; go to FETCH.
  - hit and count == NUM_SLOTS: set overflow; no fetch.
  - no fetch: if idx==NUM_ENT-1 go to DONE, else idx++.
- FETCH, one cycle:
  - slot[count] <= {rom_data, x, idx, valid=1}; count++; rom_read_enable<=0.
  - if idx==NUM_ENT-1 go to DONE, else idx++ and go to SCAN.
- DONE: line_ready=1 until the next line_start.
- Latency: line_ready is visible after the (NUM_ENT + fetched)th rising edge following the edge that sampled line_start.
- line_start in SCAN or FETCH: abort, restart with the new line_y. Slots and overflow are cleared; rom_read_enable drops to 0 on the same edge.
- Pixel path, 1-cycle latency from hpos:
  - per slot, c = hpos - x (HW+1 wide); covered if valid && c < 8.
  - opaque if row[7-c[2:0]] == 0, so the MSB is the leftmost pixel.
  - lowest slot index wins; ties go to the lower entity index.
  - pixel_on = line_ready && any opaque slot; pixel_ent = that slot's entity index, 0 when pixel_on=0.
- Reset mid-fetch: immediate return to IDLE; all outputs 0.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined: adds output collision (1 bit). It is set, registered alongside pixel_on, when two or more slots are opaque at the same hpos while line_ready. Sticky; cleared on line_start or reset.
- Undefined: no collision port and no comparison logic.

Test Plan:
- Entity0 {valid, id=1, orient=0, x=100, y=50}, others invalid; line_start with line_y=50.
  - ROM sees ID 1, index 0, orient 0 with rom_read_enable=1 for exactly 1 cycle.
  - line_ready rises after edge 9.
  - hpos=103 -> pixel_on=1, pixel_ent=0; hpos=102 or 104 -> pixel_on=0.
- Same entity, line_y=49 and line_y=58 -> no ROM read; line_ready after edge 8; pixel_on stays 0.
- Entity3 {id=0, orient=2, x=10, y=20}, line_y=22 -> rom_line_index=2, rom_orientation=2. Returned row 0x00 makes hpos 10..17 all give pixel_on=1, pixel_ent=3.
- Five valid entities all at y=0, line_y=0 -> four fetches (entities 0-3), overflow=1, entity4 never read; line_ready after edge 12.
- Entities 1 and 5 overlap at x=40 (both opaque at 40) -> pixel_ent=1. With SPRITE_COLLISION_EN, collision=1 the cycle after hpos=40.
- line_start at cycle 3 of a scan with a new line_y, then reset low mid-FETCH:
  - restart clears slots and overflow, and the scan begins again from idx 0.
  - reset forces rom_read_enable, line_ready and pixel_on to 0 immediately.

Source files
------------

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: scans the entity table before each line, fetches covering sprite rows from ROM into slots, and streams per-pixel hits.
// Optional SPRITE_COLLISION_EN adds a sticky collision output.
module sprite_line_fetcher #(
  parameter int NUM_ENT   = 8,
  parameter int NUM_SLOTS = 4,
  parameter int HW        = 10,
  parameter int VW        = 10,
  localparam int IW = $clog2(NUM_ENT),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [VW-1:0] line_y,
  output logic [IW-1:0] ent_idx,
  input  logic          ent_valid,
  input  logic [3:0]    ent_id,
  input  logic [1:0]    ent_orient,
  input  logic [HW-1:0] ent_x,
  input  logic [VW-1:0] ent_y,
  output logic          rom_read_enable,
  output logic [3:0]    rom_sprite_ID,
  output logic [1:0]    rom_orientation,
  output logic [2:0]    rom_line_index,
  input  logic [7:0]    rom_data,
  output logic          line_ready,
  output logic          overflow,
  input  logic [HW-1:0] hpos,
  output logic          pixel_on,
  output logic [IW-1:0] pixel_ent
`ifdef SPRITE_COLLISION_EN
  ,
  output logic          collision
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  typedef struct packed {
    logic [7:0]    row;
    logic [HW-1:0] x;
    logic [IW-1:0] ent;
    logic          valid;
  } slot_t;

  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

  state_t        state, next;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic [VW-1:0] line_q;
  logic [HW-1:0] cur_x;
  slot_t         slots [NUM_SLOTS];

  logic [VW:0]   d;
  logic          hit, fetch_go, last;

  assign ent_idx = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    if (line_start) next = SCAN;
    else begin
      case (state)
        SCAN:    if (fetch_go) next = FETCH; else if (last) next = DONE;
        FETCH:   next = last ? DONE : SCAN;
        default: next = state;
      endcase
    end
  end

  always_comb begin
    d          = {1'b0, line_q} - {1'b0, ent_y};
    hit        = ent_valid && (d[VW:3] == '0);
    fetch_go   = (state == SCAN) && hit && (count != FULL);
    last       = &idx;
    line_ready = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx             <= '0;
      count           <= '0;
      line_q          <= '0;
      cur_x           <= '0;
      overflow        <= 1'b0;
      rom_read_enable <= 1'b0;
      rom_sprite_ID   <= '0;
      rom_orientation <= '0;
      rom_line_index  <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else if (line_start) begin
      // A start pulse aborts any scan in flight, so it takes priority over every state action.
      line_q          <= line_y;
      idx             <= '0;
      count           <= '0;
      overflow        <= 1'b0;
      rom_read_enable <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (fetch_go) begin
            rom_read_enable <= 1'b1;
            rom_sprite_ID   <= ent_id;
            rom_orientation <= ent_orient;
            rom_line_index  <= d[2:0];
            cur_x           <= ent_x;
          end else begin
            if (hit) overflow <= 1'b1;
            if (!last) idx <= idx + 1'b1;
          end
        end
        FETCH: begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++)
            if (count == CW'(i)) slots[i] <= '{row: rom_data, x: cur_x, ent: idx, valid: 1'b1};
          count           <= count + 1'b1;
          rom_read_enable <= 1'b0;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [NUM_SLOTS-1:0] opq;
  logic [HW:0]          c;
  logic                 any;
  logic [IW-1:0]        sel;
`ifdef SPRITE_COLLISION_EN
  logic                 multi;
`endif

  always_comb begin
    opq = '0;
    c   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      c      = {1'b0, hpos} - {1'b0, slots[i].x};
      // Row MSB is the leftmost pixel, so column c selects bit 7-c.
      opq[i] = slots[i].valid && (c[HW:3] == '0) && !slots[i].row[~c[2:0]];
    end
  end

  always_comb begin
    any = 1'b0;
    sel = '0;
`ifdef SPRITE_COLLISION_EN
    multi = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (opq[i] && !any) begin
        any = 1'b1;
        sel = slots[i].ent;
      end
`ifdef SPRITE_COLLISION_EN
      else if (opq[i]) multi = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_on  <= 1'b0;
      pixel_ent <= '0;
`ifdef SPRITE_COLLISION_EN
      collision <= 1'b0;
`endif
    end else begin
      pixel_on  <= line_ready && any;
      pixel_ent <= (line_ready && any) ? sel : '0;
`ifdef SPRITE_COLLISION_EN
      if (line_start)                collision <= 1'b0;
      else if (line_ready && multi)  collision <= 1'b1;
`endif
    end
  end

endmodule
